dkong_rom_sched: RTL and testbench

- 16-slot time-division scheduler for the single shared ROM dpram, which holds CPU program, tile/sprite graphics, wave samples and config images.
- Issues one ROM address per slot and captures each requester's data into holding registers.
- Also runs the one-shot boot config-copy sequencer, which feeds the sound-ROM, palette and VRAM-attribute loads.
- Sits between the ROM dpram and the CPU, video, obj and sound blocks. Clocked at 12.288 MHz.

---
 rtl/dkong_rom_pkg.sv | 89 ++++++++
 rtl/dkong_cnf_seq.sv | 52 +++++
 rtl/dkong_rom_sched.sv | 157 +++++++++++++++
 tb/tb_dkong_rom_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dkong_rom_pkg.sv
// dkong_rom_pkg
// Shared constants and helpers for the ROM time-division scheduler:
//   - slot numbers in which each requester gets its address onto the ROM
//   - default base nibbles for tile and sprite planes
//   - default last config address and config region decode values
//   - slot_issue(): which requester owns the ROM address in a given slot
//   - cnf_we_decode(): config-copy write-enable decode
// Optional build macro: DKONG_WAV_SLOT_EN (slot 0 serves the wave requester).
package dkong_rom_pkg;

  // Slot in which each address is issued; data is captured one slot later.
  localparam logic [3:0] SLOT_WAV    = 4'd0;
  localparam logic [3:0] SLOT_CPU_A0 = 4'd2;
  localparam logic [3:0] SLOT_VID1   = 4'd3;
  localparam logic [3:0] SLOT_VID2   = 4'd4;
  localparam logic [3:0] SLOT_CPU_A1 = 4'd5;
  localparam logic [3:0] SLOT_CPU_A2 = 4'd8;
  localparam logic [3:0] SLOT_OBJ1   = 4'd9;
  localparam logic [3:0] SLOT_OBJ2   = 4'd10;
  localparam logic [3:0] SLOT_CPU_A3 = 4'd11;
  localparam logic [3:0] SLOT_OBJ3   = 4'd12;
  localparam logic [3:0] SLOT_OBJ4   = 4'd13;
  localparam logic [3:0] SLOT_CNF    = 4'd15;  // CPU address plus config advance

  localparam logic [6:0]  VID1_BASE_DEF = 7'h06;
  localparam logic [6:0]  VID2_BASE_DEF = 7'h07;
  localparam logic [3:0]  OBJ_BASE_DEF  = 4'hA;
  localparam logic [12:0] CNF_CNT_DEF   = 13'h12FF;

  // Config images live at ROM 0x0E000 upward.
  localparam logic [5:0] CNF_ROM_BASE = 6'b000111;

  // Config region decode on address bits [12:8] / [12:11].
  localparam logic [1:0] CNF_SND0_HI = 2'd0;
  localparam logic [1:0] CNF_SND1_HI = 2'd1;
  localparam logic [4:0] CNF_COL0_HI = 5'h10;
  localparam logic [4:0] CNF_COL1_HI = 5'h11;
  localparam logic [4:0] CNF_ATTR_HI = 5'h12;

  typedef enum logic [3:0] {
    REQ_NONE,
    REQ_CPU,
    REQ_WAV,
    REQ_VID1,
    REQ_VID2,
    REQ_OBJ1,
    REQ_OBJ2,
    REQ_OBJ3,
    REQ_OBJ4
  } req_e;

  // Owner of the ROM address in a slot. Because every read has exactly one
  // slot of latency, the owner of slot s-1 is also who captures in slot s.
  function automatic req_e slot_issue(input logic [3:0] slot);
    req_e req;
    req = REQ_NONE;
    case (slot)
`ifdef DKONG_WAV_SLOT_EN
      SLOT_WAV:    req = REQ_WAV;
`endif
      SLOT_CPU_A0: req = REQ_CPU;
      SLOT_VID1:   req = REQ_VID1;
      SLOT_VID2:   req = REQ_VID2;
      SLOT_CPU_A1: req = REQ_CPU;
      SLOT_CPU_A2: req = REQ_CPU;
      SLOT_OBJ1:   req = REQ_OBJ1;
      SLOT_OBJ2:   req = REQ_OBJ2;
      SLOT_CPU_A3: req = REQ_CPU;
      SLOT_OBJ3:   req = REQ_OBJ3;
      SLOT_OBJ4:   req = REQ_OBJ4;
      SLOT_CNF:    req = REQ_CPU;
      default:     req = REQ_NONE;
    endcase
    return req;
  endfunction

  // [0] sound0, [1] sound1, [2] col0, [3] col1, [4] vram attr
  function automatic logic [4:0] cnf_we_decode(input logic [12:0] a, input logic en);
    logic [4:0] we;
    we    = '0;
    we[0] = (a[12:11] == CNF_SND0_HI);
    we[1] = (a[12:11] == CNF_SND1_HI);
    we[2] = (a[12:8] == CNF_COL0_HI);
    we[3] = (a[12:8] == CNF_COL1_HI);
    we[4] = (a[12:8] == CNF_ATTR_HI);
    return en ? we : 5'd0;
  endfunction

endpackage

// File: rtl/dkong_cnf_seq.sv
// dkong_cnf_seq
// One-shot boot config-copy sequencer. Walks the config address from 0 to
// CNF_CNT+1, one step per frame, then parks there until reset.
// Ports:
//   clk, srst  clock and synchronous active-high reset
//   adv        one-cycle strobe in the config-advance slot
//   en         copy active (address has not reached CNF_CNT+1)
//   addr       current config address (13 bits)
//   we         write enables: [0] snd0 [1] snd1 [2] col0 [3] col1 [4] attr
module dkong_cnf_seq
  import dkong_rom_pkg::*;
#(
  parameter logic [12:0] CNF_CNT = CNF_CNT_DEF
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        adv,
  output logic        en,
  output logic [12:0] addr,
  output logic [4:0]  we
);

  localparam logic [12:0] CNF_END = CNF_CNT + 13'd1;

  logic [12:0] cnf_a_reg;
  logic [12:0] cnf_a_next;
  logic [4:0]  we_reg;

  always_comb begin
    cnf_a_next = cnf_a_reg;
    if (adv && (cnf_a_reg != CNF_END)) begin
      cnf_a_next = cnf_a_reg + 13'd1;
    end
  end

  // The enables are registered from the next address so they track addr
  // cycle-for-cycle yet still read as zero while reset is held.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnf_a_reg <= '0;
      we_reg    <= '0;
    end else begin
      cnf_a_reg <= cnf_a_next;
      we_reg    <= cnf_we_decode(cnf_a_next, cnf_a_next != CNF_END);
    end
  end

  assign en   = (cnf_a_reg != CNF_END);
  assign addr = cnf_a_reg;
  assign we   = we_reg;

endmodule

// File: rtl/dkong_rom_sched.sv
// dkong_rom_sched
// 16-slot time-division scheduler for the single shared ROM dpram. Each slot
// issues one ROM address and captures the data of the previous slot's read
// into the owning requester's holding register. Also hosts the boot
// config-copy sequencer, whose data stream is O_VID2_D.
// Ports:
//   I_CLK, I_RST        12.288 MHz clock, synchronous active-high reset
//   I_SYNC              phase-align level; its rising edge restarts slot 0
//   I_CPU_A/WAV_A/VID_A/OBJ_A  requester addresses
//   I_ROM_D             ROM q (read on falling edge, valid next rising edge)
//   O_ROM_A             ROM address
//   O_CPU_D, O_WAV_D, O_VID1_D, O_VID2_D, O_OBJ1_D..O_OBJ4_D  data holds
//   O_CNF_EN/O_CNF_A/O_CNF_WE  config copy status, address, write enables
//   O_PHASE             current slot
// Build macro DKONG_WAV_SLOT_EN: when defined slot 0 issues I_WAV_A and slot
// 1 captures O_WAV_D; when undefined slot 0 holds the CPU address and
// O_WAV_D is tied to zero.
module dkong_rom_sched
  import dkong_rom_pkg::*;
#(
  parameter logic [12:0] CNF_CNT   = CNF_CNT_DEF,
  parameter logic [6:0]  VID1_BASE = VID1_BASE_DEF,
  parameter logic [6:0]  VID2_BASE = VID2_BASE_DEF,
  parameter logic [3:0]  OBJ_BASE  = OBJ_BASE_DEF
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_SYNC,
  input  logic [15:0] I_CPU_A,
  input  logic [18:0] I_WAV_A,
  input  logic [11:0] I_VID_A,
  input  logic [11:0] I_OBJ_A,
  input  logic [7:0]  I_ROM_D,
  output logic [18:0] O_ROM_A,
  output logic [7:0]  O_CPU_D,
  output logic [7:0]  O_WAV_D,
  output logic [7:0]  O_VID1_D,
  output logic [7:0]  O_VID2_D,
  output logic [7:0]  O_OBJ1_D,
  output logic [7:0]  O_OBJ2_D,
  output logic [7:0]  O_OBJ3_D,
  output logic [7:0]  O_OBJ4_D,
  output logic        O_CNF_EN,
  output logic [12:0] O_CNF_A,
  output logic [4:0]  O_CNF_WE,
  output logic [3:0]  O_PHASE
);

  logic [1:0]       sync_reg;
  logic [3:0]       phase_reg;
  logic [18:0]      rom_a_reg;
  logic [18:0]      rom_a_next;
  logic [7:0]       cpu_d_reg;
  logic [7:0]       vid1_d_reg;
  logic [7:0]       vid2_d_reg;
  logic [3:0][7:0]  obj_d_reg;
  logic [18:0]      obj_addr [4];
  logic             cnf_en;
  logic [12:0]      cnf_a;
  req_e             issue_req;
  req_e             capture_req;

  // Sprite planes sit in consecutive 4 KB pages starting at OBJ_BASE.
  for (genvar gi = 0; gi < 4; gi++) begin : g_obj_addr
    assign obj_addr[gi] = {3'h0, OBJ_BASE + 4'(gi), I_OBJ_A};
  end

  assign issue_req   = slot_issue(phase_reg);
  assign capture_req = slot_issue(phase_reg - 4'd1);

  always_comb begin
    rom_a_next = rom_a_reg;
    case (issue_req)
      REQ_CPU:  rom_a_next = {3'h0, I_CPU_A};
`ifdef DKONG_WAV_SLOT_EN
      REQ_WAV:  rom_a_next = I_WAV_A;
`endif
      REQ_VID1: rom_a_next = {VID1_BASE, I_VID_A};
      // Plane 2 slot is lent to the config copy until it completes.
      REQ_VID2: rom_a_next = cnf_en ? {CNF_ROM_BASE, cnf_a} : {VID2_BASE, I_VID_A};
      REQ_OBJ1: rom_a_next = obj_addr[0];
      REQ_OBJ2: rom_a_next = obj_addr[1];
      REQ_OBJ3: rom_a_next = obj_addr[2];
      REQ_OBJ4: rom_a_next = obj_addr[3];
      default:  rom_a_next = rom_a_reg;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      sync_reg   <= '0;
      phase_reg  <= '0;
      rom_a_reg  <= '0;
      cpu_d_reg  <= '0;
      vid1_d_reg <= '0;
      vid2_d_reg <= '0;
      obj_d_reg  <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], I_SYNC};
      // Rising sync restarts the frame wherever we are.
      phase_reg <= (sync_reg[0] & ~sync_reg[1]) ? 4'd0 : phase_reg + 4'd1;
      rom_a_reg <= rom_a_next;
      case (capture_req)
        REQ_CPU:  cpu_d_reg    <= I_ROM_D;
        REQ_VID1: vid1_d_reg   <= I_ROM_D;
        REQ_VID2: vid2_d_reg   <= I_ROM_D;
        REQ_OBJ1: obj_d_reg[0] <= I_ROM_D;
        REQ_OBJ2: obj_d_reg[1] <= I_ROM_D;
        REQ_OBJ3: obj_d_reg[2] <= I_ROM_D;
        REQ_OBJ4: obj_d_reg[3] <= I_ROM_D;
        default:  ;
      endcase
    end
  end

`ifdef DKONG_WAV_SLOT_EN
  logic [7:0] wav_d_reg;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wav_d_reg <= '0;
    end else if (capture_req == REQ_WAV) begin
      wav_d_reg <= I_ROM_D;
    end
  end

  assign O_WAV_D = wav_d_reg;
`else
  logic unused_wav_a;
  assign unused_wav_a = ^I_WAV_A;
  assign O_WAV_D      = 8'h00;
`endif

  dkong_cnf_seq #(
    .CNF_CNT (CNF_CNT)
  ) u_cnf_seq (
    .clk  (I_CLK),
    .srst (I_RST),
    .adv  (phase_reg == SLOT_CNF),
    .en   (cnf_en),
    .addr (cnf_a),
    .we   (O_CNF_WE)
  );

  assign O_ROM_A  = rom_a_reg;
  assign O_CPU_D  = cpu_d_reg;
  assign O_VID1_D = vid1_d_reg;
  assign O_VID2_D = vid2_d_reg;
  assign O_OBJ1_D = obj_d_reg[0];
  assign O_OBJ2_D = obj_d_reg[1];
  assign O_OBJ3_D = obj_d_reg[2];
  assign O_OBJ4_D = obj_d_reg[3];
  assign O_CNF_EN = cnf_en;
  assign O_CNF_A  = cnf_a;
  assign O_PHASE  = phase_reg;

endmodule

// File: tb/tb_dkong_rom_sched.sv
// Testbench for dkong_rom_sched: random requester addresses and sync pulses,
// a ROM model on the falling edge, and a slot-table reference model.
module tb_dkong_rom_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic [15:0] cpu_a;
  logic [18:0] wav_a;
  logic [11:0] vid_a;
  logic [11:0] obj_a;
  logic [7:0]  rom_d = 8'h00;

  logic [18:0] O_ROM_A;
  logic [7:0]  O_CPU_D, O_WAV_D, O_VID1_D, O_VID2_D;
  logic [7:0]  O_OBJ1_D, O_OBJ2_D, O_OBJ3_D, O_OBJ4_D;
  logic        O_CNF_EN;
  logic [12:0] O_CNF_A;
  logic [4:0]  O_CNF_WE;
  logic [3:0]  O_PHASE;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dkong_rom_sched dut (
    .I_CLK   (clk),
    .I_RST   (rst),
    .I_SYNC  (sync),
    .I_CPU_A (cpu_a),
    .I_WAV_A (wav_a),
    .I_VID_A (vid_a),
    .I_OBJ_A (obj_a),
    .I_ROM_D (rom_d),
    .O_ROM_A (O_ROM_A),
    .O_CPU_D (O_CPU_D),
    .O_WAV_D (O_WAV_D),
    .O_VID1_D(O_VID1_D),
    .O_VID2_D(O_VID2_D),
    .O_OBJ1_D(O_OBJ1_D),
    .O_OBJ2_D(O_OBJ2_D),
    .O_OBJ3_D(O_OBJ3_D),
    .O_OBJ4_D(O_OBJ4_D),
    .O_CNF_EN(O_CNF_EN),
    .O_CNF_A (O_CNF_A),
    .O_CNF_WE(O_CNF_WE),
    .O_PHASE (O_PHASE)
  );

  // ROM contents: a hash of the address so any wrong address bit shows.
  function automatic logic [7:0] rom_q(input logic [18:0] a);
    return ~a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
  endfunction

  // ROM dpram: samples the address on the falling edge.
  always @(negedge clk) rom_d = rom_q(O_ROM_A);

  // Requester ids: 0 none, 1 CPU, 2 WAV, 3 VID1, 4 VID2/config, 5..8 OBJ1..4
`ifdef DKONG_WAV_SLOT_EN
  localparam int WAV_ID = 2;
`else
  localparam int WAV_ID = 0;
`endif
  localparam int SRC_TAB [16] = '{WAV_ID, 0, 1, 3, 4, 1, 0, 0, 1, 5, 6, 1, 7, 8, 0, 1};
  localparam int CAP_TAB [16] = '{1, WAV_ID, 0, 1, 3, 4, 1, 0, 0, 1, 5, 6, 1, 7, 8, 0};
  localparam int CNF_END = 'h1300;

  // Reference model state
  int          m_cnt;      // cycles since the last frame anchor
  bit          sh0, sh1;   // last two sampled sync levels
  logic [18:0] m_addr;
  logic [7:0]  m_d [9];
  int          m_cnf;
  bit          m_fresh;    // first cycle after a reset edge

  function automatic logic [18:0] m_src_addr(input int id);
    logic [3:0] nib;
    nib = 4'(10 + id - 5);
    case (id)
      1: return {3'h0, cpu_a};
      2: return wav_a;
      3: return {7'h06, vid_a};
      4: return (m_cnf != CNF_END) ? {6'b000111, 13'(m_cnf)} : {7'h07, vid_a};
      default: return {3'h0, nib, obj_a};
    endcase
  endfunction

  function automatic logic [4:0] we_of(input int a);
    if (a == CNF_END) return 5'd0;
    if (a < 'h800) return 5'd1;
    if (a < 'h1000) return 5'd2;
    if (a < 'h1100) return 5'd4;
    if (a < 'h1200) return 5'd8;
    return 5'd16;
  endfunction

  task automatic model_edge();
    int          p;
    logic [7:0]  q;
    logic [18:0] na;
    if (rst) begin
      m_cnt = 0; sh0 = 0; sh1 = 0; m_addr = '0; m_cnf = 0; m_fresh = 1;
      for (int i = 0; i < 9; i++) m_d[i] = 8'h00;
    end else begin
      p  = m_cnt % 16;
      q  = rom_q(m_addr);
      na = (SRC_TAB[p] != 0) ? m_src_addr(SRC_TAB[p]) : m_addr;
      if (CAP_TAB[p] != 0) m_d[CAP_TAB[p]] = q;
      m_addr = na;
      if (p == 15 && m_cnf != CNF_END) m_cnf++;
      if (sh0 && !sh1) m_cnt = 0; else m_cnt++;
      sh1 = sh0; sh0 = sync;
      m_fresh = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("phase",  32'(O_PHASE),  32'(m_cnt % 16));
    chk("rom_a",  32'(O_ROM_A),  32'(m_addr));
    chk("cpu_d",  32'(O_CPU_D),  32'(m_d[1]));
    chk("wav_d",  32'(O_WAV_D),  32'(m_d[2]));
    chk("vid1_d", 32'(O_VID1_D), 32'(m_d[3]));
    chk("vid2_d", 32'(O_VID2_D), 32'(m_d[4]));
    chk("obj_d",  {O_OBJ1_D, O_OBJ2_D, O_OBJ3_D, O_OBJ4_D}, {m_d[5], m_d[6], m_d[7], m_d[8]});
    chk("cnf_en", 32'(O_CNF_EN), 32'(m_cnf != CNF_END));
    chk("cnf_a",  32'(O_CNF_A),  32'(m_cnf));
    chk("cnf_we", 32'(O_CNF_WE), m_fresh ? 32'd0 : 32'(we_of(m_cnf)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_inputs(input bit allow_sync);
    cpu_a = 16'($urandom);
    wav_a = 19'($urandom);
    vid_a = 12'($urandom);
    obj_a = 12'($urandom);
    sync  = allow_sync ? ($urandom_range(0, 30) == 0) : 1'b0;
  endtask

  // Two frames of fixed addresses; explicit checks on the second frame.
  task automatic directed_frames(input bit cnf_done);
    int p;
    logic [18:0] exp_wav_addr;
    logic [7:0]  exp_wav_d;
`ifdef DKONG_WAV_SLOT_EN
    exp_wav_addr = 19'h7ABCD;
    exp_wav_d    = rom_q(19'h7ABCD);
`else
    exp_wav_addr = 19'h01234;
    exp_wav_d    = 8'h00;
`endif
    cpu_a = 16'h1234; vid_a = 12'h5A5; obj_a = 12'h0F0; wav_a = 19'h7ABCD; sync = 1'b0;
    for (int k = 0; k < 32; k++) begin
      cycle();
      p = m_cnt % 16;
      if (k >= 16) begin
        if (p == 3 || p == 6 || p == 9 || p == 12 || p == 0) chk("dir_cpu_addr", 32'(O_ROM_A), 32'h01234);
        if (p == 4 || p == 7 || p == 10 || p == 13 || p == 1) chk("dir_cpu_d", 32'(O_CPU_D), 32'(rom_q(19'h01234)));
        if (p == 4)  chk("dir_vid1_addr", 32'(O_ROM_A), 32'h065A5);
        if (p == 5)  chk("dir_vid1_d", 32'(O_VID1_D), 32'(rom_q(19'h065A5)));
        if (p == 5 && cnf_done) chk("dir_vid2_addr", 32'(O_ROM_A), 32'h075A5);
        if (p == 6 && cnf_done) chk("dir_vid2_d", 32'(O_VID2_D), 32'(rom_q(19'h075A5)));
        if (p == 10) chk("dir_obj1_addr", 32'(O_ROM_A), 32'h0A0F0);
        if (p == 11) chk("dir_obj2_addr", 32'(O_ROM_A), 32'h0B0F0);
        if (p == 13) chk("dir_obj3_addr", 32'(O_ROM_A), 32'h0C0F0);
        if (p == 14) chk("dir_obj4_addr", 32'(O_ROM_A), 32'h0D0F0);
        if (p == 11) chk("dir_obj1_d", 32'(O_OBJ1_D), 32'(rom_q(19'h0A0F0)));
        if (p == 15) chk("dir_obj4_d", 32'(O_OBJ4_D), 32'(rom_q(19'h0D0F0)));
        if (p == 1)  chk("dir_wav_addr", 32'(O_ROM_A), 32'(exp_wav_addr));
        if (p == 2)  chk("dir_wav_d", 32'(O_WAV_D), 32'(exp_wav_d));
      end
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; cpu_a = '0; wav_a = '0; vid_a = '0; obj_a = '0;
    m_cnt = 0; sh0 = 0; sh1 = 0; m_addr = '0; m_cnf = 0; m_fresh = 1;
    for (int i = 0; i < 9; i++) m_d[i] = 8'h00;

    // Reset state
    repeat (3) cycle();
    chk("rst_rom_a", 32'(O_ROM_A), 32'd0);
    chk("rst_phase", 32'(O_PHASE), 32'd0);
    chk("rst_cnf_en", 32'(O_CNF_EN), 32'd1);
    chk("rst_cnf_we", 32'(O_CNF_WE), 32'd0);
    chk("rst_cpu_d", 32'(O_CPU_D), 32'd0);
    rst = 1'b0;

    // Phase alignment: sync pulse, phase 0 two clocks later, then 1..15,0
    repeat (5) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    cycle();
    chk("sync_phase0", 32'(O_PHASE), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      cycle();
      chk("phase_count", 32'(O_PHASE), 32'(k % 16));
    end
    chk("cnf_a_start", 32'(O_CNF_A), 32'd1);

    // Directed addresses while the copy is still running
    directed_frames(1'b0);

    // Random addresses with occasional sync edges
    for (int k = 0; k < 640; k++) begin
      rand_inputs(1'b1);
      cycle();
    end

    // Reset in the middle of the copy
    for (int k = 0; k < 'h41 * 16 && m_cnf < 'h40; k++) begin
      rand_inputs(1'b0);
      cycle();
    end
    chk("midcopy_reached", 32'(O_CNF_A), 32'h40);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midcopy_rst_a", 32'(O_CNF_A), 32'd0);
    chk("midcopy_rst_en", 32'(O_CNF_EN), 32'd1);

    // Full copy from address 0 to the end
    for (int k = 0; k < CNF_END * 16 + 32 && m_cnf != CNF_END; k++) begin
      rand_inputs(1'b0);
      cycle();
    end
    chk("copy_done_en", 32'(O_CNF_EN), 32'd0);
    chk("copy_done_a", 32'(O_CNF_A), 32'h1300);
    chk("copy_done_we", 32'(O_CNF_WE), 32'd0);

    // Copy stays finished, including across sync edges
    for (int k = 0; k < 48; k++) begin
      rand_inputs(1'b1);
      cycle();
    end
    chk("copy_sticky_en", 32'(O_CNF_EN), 32'd0);
    sync = 1'b0;
    repeat (3) cycle();

    // Directed addresses with plane 2 back on tile data
    directed_frames(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
